// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the vector data memory arbiter.
//   word_t      - one memory word, DMEM_LANES x DMEM_LANE_W packed
//   addr_t      - word address
//   arb_state_t - arbiter state (round-robin or locked to one owner)
package dmem_pkg;
  localparam int DMEM_DEPTH  = 10924;
  localparam int DMEM_LANES  = 6;
  localparam int DMEM_LANE_W = 8;
  localparam int DMEM_ADDR_W = 17;

  typedef logic [DMEM_LANES-1:0][DMEM_LANE_W-1:0] word_t;
  typedef logic [DMEM_ADDR_W-1:0]                 addr_t;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req - request vector
//   ptr - highest-priority index; search runs ptr, ptr+1, ... mod N
//   gnt - one-hot grant (zero when no request)
//   idx - granted index (0 when no request)
//   any - a request was found
module rr_pick
  import dmem_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = PW'(c);
      end
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port vector data memory between N_REQ
// requesters with round-robin arbitration, bounded bursts (lock) and
// out-of-range protection. Responses are registered one cycle after grant.
//   clk, rst_n          - clock, synchronous active-low reset
//   req/we/addr/wdata/lock - per-requester access, held until gnt
//   gnt                 - combinational one-hot grant; access happens that cycle
//   rsp_valid/rsp_err   - registered response to the granted requester
//   rdata               - registered read word (0 for writes/errors)
//   mem_we/mem_a/mem_wd/mem_rd - direct connection to data_mem
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int LANES    = DMEM_LANES,
  parameter int LANE_W   = DMEM_LANE_W,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int MAX_LOCK = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_REQ-1:0]                          req,
  input  logic [N_REQ-1:0]                          we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]              addr,
  input  logic [N_REQ-1:0][LANES-1:0][LANE_W-1:0]   wdata,
  input  logic [N_REQ-1:0]                          lock,
  output logic [N_REQ-1:0]                          gnt,
  output logic [N_REQ-1:0]                          rsp_valid,
  output logic [N_REQ-1:0]                          rsp_err,
  output logic [LANES-1:0][LANE_W-1:0]              rdata,
  output logic                                      mem_we,
  output logic [ADDR_W-1:0]                         mem_a,
  output logic [LANES-1:0][LANE_W-1:0]              mem_wd,
  input  logic [LANES-1:0][LANE_W-1:0]              mem_rd
);
  localparam int               PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [7:0]        MAX_C   = 8'(MAX_LOCK);

  arb_state_t    state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, owner, owner_nx, pidx, gidx;
  logic [7:0]    lock_cnt, cnt_nx;
  logic [N_REQ-1:0] pgnt;
  logic          pany, any, in_range, gwe;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pgnt),
    .idx (pidx),
    .any (pany)
  );

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    cnt_nx   = lock_cnt;
    ptr_nx   = ptr;
    gnt      = '0;
    gidx     = owner;
    any      = 1'b0;
    if (!rst_n) begin
      // Requests seen during reset are left pending, not granted.
    end else if (state == LOCKED && req[owner]) begin
      any        = 1'b1;
      gnt[owner] = 1'b1;
      if (!lock[owner] || (lock_cnt + 8'd1) >= MAX_C) begin
        state_nx = IDLE;
        cnt_nx   = '0;
        ptr_nx   = inc(owner);
      end else begin
        cnt_nx = lock_cnt + 8'd1;
      end
    end else begin
      // IDLE, or owner dropped req: ptr already sits at owner+1, so the
      // release and a fresh round-robin grant share this cycle.
      state_nx = IDLE;
      cnt_nx   = '0;
      if (pany) begin
        any    = 1'b1;
        gidx   = pidx;
        gnt    = pgnt;
        ptr_nx = inc(pidx);
        if (lock[pidx] && MAX_LOCK > 1) begin
          state_nx = LOCKED;
          owner_nx = pidx;
          cnt_nx   = 8'd1;
        end
      end
    end
  end

  always_comb begin
    in_range = addr[gidx] < DEPTH_A;
    gwe      = we[gidx];
    mem_we   = any && gwe && in_range;
    mem_a    = any ? addr[gidx]  : '0;
    mem_wd   = any ? wdata[gidx] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      lock_cnt  <= cnt_nx;
      rsp_valid <= gnt;
      rsp_err   <= in_range ? '0 : gnt;
      if (any) rdata <= (!gwe && in_range) ? mem_rd : '0;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port vector data memory (6 lanes x 8 bit words, 17-bit word address, 10924 words, write on clock edge, combinational read) between N_REQ requesters, e.g. the vector load/store unit and the host/DMA loader.
- Round-robin arbitration with optional bounded locking for bursts and out-of-range address protection.
- Registered one-cycle response path back to the winning requester.
- Sits between the requesters and data_mem; its memory-side ports connect directly to data_mem.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- ADDR_W, 17, word address width.
- LANES, 6, byte lanes per word.
- LANE_W, 8, bits per lane.
- DEPTH, 10924, valid words; addresses >= DEPTH are out of range.
- MAX_LOCK, 16, maximum consecutive locked grants to one owner (1..255).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  request per requester; addr/we/wdata/lock are held stable until the matching gnt.
- we  in  N_REQ  1 = write, 0 = read.
- addr  in  N_REQ x ADDR_W  word address per requester.
- wdata  in  N_REQ x LANES x LANE_W  write word per requester.
- lock  in  N_REQ  keep ownership after this access.
- gnt  out  N_REQ  one-hot or zero, combinational; the access executes in the cycle gnt is high.
- rsp_valid  out  N_REQ  registered; pulses one cycle after the grant, to the granted requester only.
- rsp_err  out  N_REQ  registered; qualifies rsp_valid; 1 = out-of-range address.
- rdata  out  LANES x LANE_W  registered read word, shared by all requesters.
- mem_we  out  1  to data_mem WE.
- mem_a  out  ADDR_W  to data_mem A.
- mem_wd  out  LANES x LANE_W  to data_mem WD.
- mem_rd  in  LANES x LANE_W  from data_mem RD.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - ptr=0, state=IDLE, owner=0, lock_cnt=0.
  - rsp_valid=0, rsp_err=0, rdata=0.
  - gnt, mem_we, mem_a and mem_wd are forced to 0 while rst_n=0.
  - Requests present during reset are neither granted nor lost; they are arbitrated after release.
- States: IDLE (round-robin) and LOCKED (owner holds memory).
- IDLE arbitration:
  - Grant the first i with req[i]=1, searching ptr, ptr+1, ... mod N_REQ.
  - On a grant to i: ptr <= (i+1) mod N_REQ.
  - If lock[i]=1: go to LOCKED with owner=i and lock_cnt=1.
- LOCKED:
  - If req[owner]=1: grant owner unconditionally and lock_cnt++.
  - Release to IDLE (owner excluded next cycle via ptr=owner+1) when any of these holds:
    - owner is granted with lock=0 (release after that access);
    - req[owner]=0, in which case normal round-robin runs in that same cycle and no cycle is lost;
    - lock_cnt reaches MAX_LOCK after the current grant (forced release).
  - Other requesters are never granted while the owner is granted.
- Memory drive:
  - For the granted i: mem_a=addr[i], mem_wd=wdata[i], mem_we=we[i] and in_range.
  - in_range is addr[i] < DEPTH.
  - With no grant: mem_we=0, mem_a=0, mem_wd=0.
- Response, one cycle after the grant of i:
  - rsp_valid[i]=1.
  - rsp_err[i]=!in_range.
  - rdata = mem_rd sampled in the grant cycle for in-range reads, else 0. Writes and errored accesses give rdata=0.
  - rsp_valid/rsp_err for non-granted requesters are 0. rdata holds its value when no response is issued.
- Timing and throughput:
  - Latency is request-to-grant 0 cycles if uncontested, and grant-to-response 1 cycle.
  - Throughput is one access per cycle, back-to-back.
- Out-of-range accesses:
  - They are consumed (gnt=1) with no memory write, and respond with rsp_err=1.
  - They do not affect ptr or lock rules differently from normal accesses.
- Simultaneous events:
  - Same-cycle requests are resolved purely by ptr.
  - A requester dropping req while in IDLE is simply skipped.
  - Mid-operation reset drops any pending response (rsp_valid=0 next cycle).

Decomposition:
- Package dmem_pkg:
  - Typedefs: word_t (LANES x LANE_W packed), addr_t (ADDR_W).
  - Constants: DMEM_DEPTH=10924, DMEM_LANES=6, DMEM_LANE_W=8.
  - State enum arb_state_t {IDLE, LOCKED}.
- Sub-module rr_pick (combinational):
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and granted index.
  - Instantiated once for IDLE arbitration.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles with req=2'b11 -> gnt=0, mem_we=0, rsp_valid=0, rdata=0; after release, gnt=2'b01 (ptr=0).
- Round-robin: req=2'b11 held 4 cycles, all reads -> gnt sequence 01,10,01,10; rsp_valid follows one cycle later each time.
- Write-read: req0 write addr=0x00005, wdata=0x0A0B0C0D0E0F, then read 0x00005 -> mem_we=1 in the write cycle; the read response has rdata=0x0A0B0C0D0E0F, rsp_err=0.
- Lock burst: req0 lock=1 for 3 beats then lock=0, req1 held high -> gnt0 for 4 consecutive cycles, then gnt1 in cycle 5.
- Forced release: MAX_LOCK=4, req0 lock=1 held indefinitely, req1 high -> gnt0 x4, gnt1 x1, then gnt0 again.
- Out of range: req1 write addr=10924 (0x02AAC), then read 0x1FFFF -> gnt1 both cycles, mem_we=0; responses have rsp_err[1]=1, rdata=0; memory at 0x02AAC unchanged.
